// File: rtl/difftest_step_arbiter.sv
// Round-robin arbiter that shares one simulator step channel among NUM_CORES difftest cores.
// Optional response watchdog is enabled by defining DIFFTEST_STEP_ARB_TIMEOUT_EN.
module difftest_step_arbiter #(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned STEP_WIDTH     = 8,
    parameter int unsigned ACC_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned CoreW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
    output logic                            req_valid,
    input  logic                            req_ready,
    output logic [CoreW-1:0]                req_core,
    output logic [STEP_WIDTH-1:0]           req_nstep,
    input  logic                            rsp_valid,
    input  logic [7:0]                      rsp_result,
    output logic [NUM_CORES-1:0]            core_done,
    output logic [7:0]                      sim_result,
    output logic                            all_done,
    output logic [NUM_CORES-1:0]            overflow,
    output logic                            timeout
);

    localparam int unsigned AccPad = ACC_WIDTH + 1 - STEP_WIDTH;
    localparam logic [ACC_WIDTH-1:0] StepMax = ACC_WIDTH'({STEP_WIDTH{1'b1}});
    localparam logic [7:0] ResRunning = 8'd0;
    localparam logic [7:0] ResGood    = 8'd1;
    localparam logic [7:0] ResExceed  = 8'd2;
    localparam logic [7:0] ResFail    = 8'd3;
    localparam logic [7:0] ResWarmup  = 8'd4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_CORES];
    logic [ACC_WIDTH-1:0]   acc_d [NUM_CORES];
    logic [NUM_CORES-1:0]   ovf_set;
    logic [NUM_CORES-1:0]   overflow_q;
    logic [NUM_CORES-1:0]   core_done_q;
    logic [NUM_CORES-1:0]   elig;
    logic [NUM_CORES-1:0]   done_set;
    logic [CoreW-1:0]       ptr_q;
    logic [CoreW-1:0]       ptr_next;
    logic [CoreW-1:0]       req_core_q;
    logic [STEP_WIDTH-1:0]  req_nstep_q;
    logic                   req_valid_q;
    logic [7:0]             sim_result_q;
    logic                   all_done_q;
    logic                   timeout_q;
    logic                   done_rsp;
    logic                   sel_found;
    logic [CoreW-1:0]       sel_idx;
    logic [ACC_WIDTH-1:0]   sel_acc;
    logic [STEP_WIDTH-1:0]  sel_nstep;
    logic [STEP_WIDTH-1:0]  step_i;
    logic [STEP_WIDTH-1:0]  issued_i;
    logic [ACC_WIDTH:0]     sum_i;
    int                     idx;

`ifdef DIFFTEST_STEP_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign done_rsp = (state_q == StWait) && rsp_valid &&
                      ((rsp_result == ResGood) || (rsp_result == ResExceed));
    assign done_set = NUM_CORES'(1) << req_core_q;

    // Accumulators: new steps in, accepted steps out, saturating at ACC_WIDTH.
    always_comb begin
        ovf_set  = '0;
        step_i   = '0;
        issued_i = '0;
        sum_i    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            step_i   = core_done_q[i] ? '0 : core_step[i*STEP_WIDTH +: STEP_WIDTH];
            issued_i = (req_valid_q && req_ready && (req_core_q == CoreW'(i))) ?
                       req_nstep_q : '0;
            sum_i    = {1'b0, acc_q[i]} + {{AccPad{1'b0}}, step_i}
                       - {{AccPad{1'b0}}, issued_i};
            if (done_rsp && (req_core_q == CoreW'(i))) begin
                acc_d[i] = '0;
            end else if (sum_i[ACC_WIDTH]) begin
                acc_d[i]   = '1;
                ovf_set[i] = 1'b1;
            end else begin
                acc_d[i] = sum_i[ACC_WIDTH-1:0];
            end
        end
    end

    // Round-robin pick: first eligible core at or after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            elig[i] = (acc_q[i] != '0) && !core_done_q[i] && (sim_result_q != ResFail);
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NUM_CORES)) idx = idx - int'(NUM_CORES);
            if (!sel_found && elig[idx]) begin
                sel_found = 1'b1;
                sel_idx   = CoreW'(idx);
            end
        end
        sel_acc   = acc_q[sel_idx];
        sel_nstep = (sel_acc > StepMax) ? '1 : sel_acc[STEP_WIDTH-1:0];
        ptr_next  = (req_core_q == CoreW'(NUM_CORES - 1)) ? '0 : req_core_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            for (int i = 0; i < NUM_CORES; i++) acc_q[i] <= '0;
            overflow_q   <= '0;
            core_done_q  <= '0;
            ptr_q        <= '0;
            req_core_q   <= '0;
            req_nstep_q  <= '0;
            req_valid_q  <= 1'b0;
            sim_result_q <= '0;
            all_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef DIFFTEST_STEP_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CORES; i++) acc_q[i] <= acc_d[i];
            overflow_q   <= overflow_q | ovf_set;
            all_done_q   <= 1'b0;
            sim_result_q <= (sim_result_q == ResFail) ? ResFail : ResRunning;
            unique case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        req_core_q  <= sel_idx;
                        req_nstep_q <= sel_nstep;
                        req_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        ptr_q       <= ptr_next;
                        state_q     <= StWait;
`ifdef DIFFTEST_STEP_ARB_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
`endif
                    end
                end
                StWait: begin
                    if (rsp_valid) begin
                        state_q <= StIdle;
                        if (rsp_result == ResFail) begin
                            sim_result_q <= ResFail;
                        end else if (done_rsp) begin
                            core_done_q <= core_done_q | done_set;
                            all_done_q  <= &(core_done_q | done_set);
                            if (sim_result_q != ResFail) sim_result_q <= rsp_result;
                        end else if (rsp_result == ResWarmup) begin
                            sim_result_q <= ResWarmup;
                        end
`ifdef DIFFTEST_STEP_ARB_TIMEOUT_EN
                    end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q    <= 1'b1;
                        sim_result_q <= ResFail;
                        state_q      <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_valid  = req_valid_q;
    assign req_core   = req_core_q;
    assign req_nstep  = req_nstep_q;
    assign core_done  = core_done_q;
    assign sim_result = sim_result_q;
    assign all_done   = all_done_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_difftest_step_arbiter.sv
// Scoreboard bench for difftest_step_arbiter (2 cores, 8-bit steps, 16-bit accumulators).
module tb_difftest_step_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] core_step = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [0:0]  req_core;
    logic [7:0]  req_nstep;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_result = '0;
    logic [1:0]  core_done;
    logic [7:0]  sim_result;
    logic        all_done;
    logic [1:0]  overflow;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int core;
        int nstep;
    } req_t;
    req_t exp_q[$];

    difftest_step_arbiter #(
        .NUM_CORES     (2),
        .STEP_WIDTH    (8),
        .ACC_WIDTH     (16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .core_step (core_step),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_core  (req_core),
        .req_nstep (req_nstep),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .core_done (core_done),
        .sim_result(sim_result),
        .all_done  (all_done),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        core_step = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_result = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits (bounded) for a request, accepts it, and optionally returns a response.
    task automatic serve(input logic [7:0] code, input bit give_rsp,
                         output int core, output int nstep, output bit ok);
        ok = 1'b0;
        core = -1;
        nstep = -1;
        for (int c = 0; c < 50; c++) begin
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        core = int'(req_core);
        nstep = int'(req_nstep);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        if (give_rsp) begin
            rsp_valid = 1'b1;
            rsp_result = code;
            tick();
            rsp_valid = 1'b0;
            rsp_result = '0;
        end
    endtask

    task automatic serve_and_compare(input logic [7:0] code, input bit give_rsp,
                                     input string name);
        int core, nstep;
        bit ok;
        req_t e;
        serve(code, give_rsp, core, nstep, ok);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: request seen with empty scoreboard", name);
        end else begin
            e = exp_q.pop_front();
            if (!ok || core !== e.core || nstep !== e.nstep) begin
                errors++;
                $display("FAIL %s: got core=%0d nstep=%0d (ok=%0d), want core=%0d nstep=%0d",
                         name, core, nstep, ok, e.core, e.nstep);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({req_valid, req_core, req_nstep, core_done, sim_result, all_done, overflow,
             timeout} !== '0) begin
            errors++;
            $display("FAIL reset: outputs v=%b c=%0d n=%0d d=%b r=%0d a=%b o=%b t=%b, want all 0",
                     req_valid, req_core, req_nstep, core_done, sim_result, all_done,
                     overflow, timeout);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        core_step = {8'd0, 8'd3};
        exp_q.push_back('{core: 0, nstep: 3});
        tick();
        core_step = '0;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1: req_valid=%b want 0", req_valid);
        end
        tick();
        checks++;
        if (req_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency2: req_valid=%b want 1", req_valid);
        end
        serve_and_compare(8'd0, 1'b1, "basic_req");
        checks++;
        if (sim_result !== 8'd0) begin
            errors++;
            $display("FAIL basic_result: sim_result=%0d want 0", sim_result);
        end
        repeat (5) tick();
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained: req_valid=%b want 0", req_valid);
        end
    endtask

    task automatic test_same_cycle();
        core_step = {8'd0, 8'd4};
        exp_q.push_back('{core: 0, nstep: 4});
        tick();
        core_step = '0;
        tick();
        // Accept the request while a new step for the same core arrives.
        req_ready = 1'b1;
        core_step = {8'd0, 8'd7};
        exp_q.push_back('{core: 0, nstep: 7});
        tick();
        req_ready = 1'b0;
        core_step = '0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL same_cycle_sb: scoreboard empty");
        end else begin
            void'(exp_q.pop_front());
        end
        rsp_valid = 1'b1;
        rsp_result = 8'd0;
        tick();
        rsp_valid = 1'b0;
        serve_and_compare(8'd0, 1'b1, "same_cycle_req");
    endtask

    task automatic test_alternate();
        int sum0 = 0, sum1 = 0, last = -1, ngr = 0;
        fork
            begin
                for (int c = 0; c < 10; c++) begin
                    core_step = {8'd1, 8'd1};
                    tick();
                end
                core_step = '0;
            end
            begin
                for (int c = 0; c < 100 && (sum0 < 10 || sum1 < 10); c++) begin
                    if (req_valid) begin
                        checks++;
                        if (last >= 0 && int'(req_core) !== 1 - last) begin
                            errors++;
                            $display("FAIL alternate_order: core=%0d want %0d", req_core,
                                     1 - last);
                        end
                        last = int'(req_core);
                        ngr++;
                        if (req_core == 1'b0) sum0 += int'(req_nstep);
                        else sum1 += int'(req_nstep);
                        req_ready = 1'b1;
                        tick();
                        req_ready = 1'b0;
                        rsp_valid = 1'b1;
                        rsp_result = 8'd0;
                        tick();
                        rsp_valid = 1'b0;
                    end else begin
                        tick();
                    end
                end
            end
        join
        checks++;
        if (sum0 !== 10 || sum1 !== 10 || ngr < 4) begin
            errors++;
            $display("FAIL alternate_sums: sum0=%0d sum1=%0d grants=%0d want 10 10 >=4",
                     sum0, sum1, ngr);
        end
    endtask

    task automatic test_chunk();
        int steps[3] = '{255, 255, 90};
        foreach (steps[i]) begin
            core_step = {8'(steps[i]), 8'd0};
            tick();
        end
        core_step = '0;
        exp_q.push_back('{core: 1, nstep: 255});
        exp_q.push_back('{core: 1, nstep: 255});
        exp_q.push_back('{core: 1, nstep: 90});
        for (int i = 0; i < 3; i++) serve_and_compare(8'd0, 1'b1, "chunk_req");
    endtask

    task automatic test_done();
        bit seen = 1'b0;
        core_step = {8'd0, 8'd2};
        exp_q.push_back('{core: 0, nstep: 2});
        tick();
        core_step = '0;
        serve_and_compare(8'd1, 1'b1, "done_req0");
        checks++;
        if (sim_result !== 8'd1 || core_done !== 2'b01 || all_done !== 1'b0) begin
            errors++;
            $display("FAIL done_core0: res=%0d done=%b all=%b want 1 01 0",
                     sim_result, core_done, all_done);
        end
        tick();
        checks++;
        if (sim_result !== 8'd0) begin
            errors++;
            $display("FAIL done_pulse1: sim_result=%0d want 0", sim_result);
        end
        core_step = {8'd3, 8'd0};
        exp_q.push_back('{core: 1, nstep: 3});
        tick();
        core_step = '0;
        serve_and_compare(8'd2, 1'b1, "done_req1");
        checks++;
        if (sim_result !== 8'd2 || core_done !== 2'b11 || all_done !== 1'b1) begin
            errors++;
            $display("FAIL done_core1: res=%0d done=%b all=%b want 2 11 1",
                     sim_result, core_done, all_done);
        end
        tick();
        checks++;
        if (sim_result !== 8'd0 || all_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse2: res=%0d all=%b want 0 0", sim_result, all_done);
        end
        core_step = {8'd5, 8'd5};
        tick();
        core_step = '0;
        for (int c = 0; c < 10; c++) begin
            if (req_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL done_drop: req_valid seen=%b want 0", seen);
        end
        apply_reset();
    endtask

    task automatic test_fail();
        bit seen = 1'b0;
        core_step = {8'd2, 8'd0};
        exp_q.push_back('{core: 1, nstep: 2});
        tick();
        core_step = '0;
        serve_and_compare(8'd3, 1'b1, "fail_req");
        core_step = {8'd0, 8'd5};
        tick();
        core_step = '0;
        for (int c = 0; c < 20; c++) begin
            if (req_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (sim_result !== 8'd3 || seen !== 1'b0) begin
            errors++;
            $display("FAIL fail_sticky: res=%0d req_seen=%b want 3 0", sim_result, seen);
        end
        apply_reset();
        checks++;
        if (sim_result !== 8'd0) begin
            errors++;
            $display("FAIL fail_reset: sim_result=%0d want 0", sim_result);
        end
    endtask

    task automatic test_overflow();
        core_step = {8'd0, 8'd255};
        repeat (260) tick();
        core_step = '0;
        checks++;
        if (overflow !== 2'b01 || req_nstep !== 8'd255 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ovf=%b nstep=%0d valid=%b want 01 255 1",
                     overflow, req_nstep, req_valid);
        end
        apply_reset();
    endtask

    task automatic test_wait_timeout();
        bit seen = 1'b0;
        core_step = {8'd0, 8'd1};
        exp_q.push_back('{core: 0, nstep: 1});
        tick();
        core_step = '0;
        serve_and_compare(8'd0, 1'b0, "wait_req");
        core_step = {8'd2, 8'd0};
        tick();
        core_step = '0;
`ifdef DIFFTEST_STEP_ARB_TIMEOUT_EN
        repeat (48) tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: timeout=%b want 0", timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || sim_result !== 8'd3) begin
            errors++;
            $display("FAIL timeout_fire: timeout=%b res=%0d want 1 3", timeout, sim_result);
        end
        apply_reset();
`else
        for (int c = 0; c < 200; c++) begin
            if (req_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (timeout !== 1'b0 || seen !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: timeout=%b req_seen=%b want 0 0", timeout, seen);
        end
        rsp_valid = 1'b1;
        rsp_result = 8'd0;
        tick();
        rsp_valid = 1'b0;
        exp_q.push_back('{core: 1, nstep: 2});
        serve_and_compare(8'd0, 1'b1, "wait_resume");
`endif
    endtask

    task automatic test_reset_abort();
        core_step = {8'd0, 8'd6};
        exp_q.push_back('{core: 0, nstep: 6});
        tick();
        core_step = '0;
        serve_and_compare(8'd0, 1'b0, "abort_req");
        apply_reset();
        rsp_valid = 1'b1;
        rsp_result = 8'd1;
        tick();
        rsp_valid = 1'b0;
        rsp_result = '0;
        checks++;
        if (core_done !== 2'b00 || sim_result !== 8'd0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_rsp: done=%b res=%0d valid=%b want 00 0 0",
                     core_done, sim_result, req_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_alternate();
        test_chunk();
        test_done();
        test_fail();
        test_overflow();
        test_wait_timeout();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
